sdf_bf_stage: RTL and testbench
===============================

SDF_BF_STAGE -- requirements
Module: sdf_bf_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 18: signed input sample width per component.
REQ-002 Parameter DELAY, default 32: feedback delay-line depth in samples; power of two, 2 to 512.
REQ-003 Parameter SCALE, default 0: 1 selects divide-by-2 with rounding on outputs; 0 selects full growth.
REQ-004 Derived OUT_WIDTH = DATA_WIDTH + 1 - SCALE; IDX_WIDTH = log2(DELAY) + 1.
REQ-005 The block has one clock; reset is asynchronous and active-high. Ports are named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 clr  input  1  synchronous frame restart; clears the sample counter and the primed flag.
REQ-009 in_valid  input  1  qualifies in_r/in_i; no backpressure exists.
REQ-010 in_r, in_i  input  DATA_WIDTH each  signed sample.
REQ-011 out_valid  output  1  qualifies out_r, out_i, out_idx and out_last.
REQ-012 out_r, out_i  output  OUT_WIDTH each  signed result.
REQ-013 out_idx  output  IDX_WIDTH  MSB 0 = sum term n, MSB 1 = difference term n; LSBs = n.
REQ-014 out_last  output  1  marks difference term n = DELAY-1, the end of an output frame.

Function
REQ-015 Counter cnt (IDX_WIDTH bits) advances by one per accepted input (in_valid=1) and wraps from 2*DELAY-1 to 0; it is frozen when in_valid=0.
REQ-016 Phase A (cnt MSB=0): the sign-extended input is written into the delay line; the delay-line output (a stored difference) is presented as the output sample.
REQ-017 Phase B (cnt MSB=1): with x = delay-line output and y = input, x+y is output and x-y is written into the delay line.
REQ-018 The delay line is DELAY x 2 x (DATA_WIDTH+1) bits, addressed by cnt LSBs, read-before-write, and advances only on accepted inputs.
REQ-019 Sum and difference are computed at DATA_WIDTH+1 bits; no wrap is possible.
REQ-020 If SCALE=1, the output is (v + 1) >>> 1, computed at DATA_WIDTH+2 bits and truncated to DATA_WIDTH; it never saturates.
REQ-021 All outputs are registered; latency is exactly 1 clk from the accepted input to out_valid.
REQ-022 out_valid=1 one cycle after every accepted phase-B input.
REQ-023 out_valid=1 one cycle after an accepted phase-A input only while primed=1.
REQ-024 primed sets when the last phase-B sample (cnt=2*DELAY-1) is accepted; it is cleared only by rst or clr.
REQ-025 While out_valid=0, out_r/out_i/out_idx/out_last hold their previous values.
REQ-026 clr takes priority over a simultaneous in_valid; that input is discarded.
REQ-027 If clr arrives mid-frame, the next accepted input is n=0 of phase A, and stale delay-line data is never emitted.

Reset
REQ-028 rst asynchronously drives cnt=0, primed=0, out_valid=0, out_last=0, out_r=out_i=0 and out_idx=0.
REQ-029 Delay-line contents are not reset; primed gating makes them unobservable.
REQ-030 rst is released synchronously by the existing top-level reset synchroniser; the block adds none.

Structure
REQ-031 Shared package fft_pkg holds the clog2 helper and the rounding-shift function; the SCALE encoding is shared with future stages.
REQ-032 Sub-module sdf_delay_line, a parametrised width/depth circular buffer, is instantiated once for the combined real/imag word.
REQ-033 The butterfly arithmetic stays inline in the stage; no separate arithmetic module is used.

Verification
REQ-034 DELAY=4, SCALE=0: real inputs 1..8 continuous, then 8 zeros -> sums 6,8,10,12 (idx 0-3); diffs -4 x4 (idx 4-7, last on idx 7); no valid output during the first 4 inputs.
REQ-035 SCALE=1: pair 131071/131071 -> sum 131071; pair -131072/131071 -> diff -131071; out_r stays 18 bits with no wrap.
REQ-036 Same stimulus as REQ-034 with 3-cycle in_valid gaps between every sample -> identical value sequence; out_valid only 1 cycle after each accepted input.
REQ-037 rst asserted mid-phase-B, then 8 new samples -> all outputs 0 during rst, no diffs from the aborted frame, first output is sum n=0 of the new frame.
REQ-038 clr together with in_valid at cnt=5 -> that sample is dropped, the next input is n=0, and out_valid stays low for the next 4 accepted inputs.
REQ-039 1000 random back-to-back frames, DATA_WIDTH=16, DELAY=32 -> bit-exact match to the reference model, with out_last every 64 accepted inputs after the first frame.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg: helpers and encodings shared by the SDF FFT stages.
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

   localparam int SCALE_FULL = 0;
   localparam int SCALE_HALF = 1;
   localparam int RND_WIDTH  = 64;

   typedef enum logic {
      PHASE_A = 1'b0,
      PHASE_B = 1'b1
   } phase_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // Divide by two, rounding half up; callers truncate the result to their width.
   function automatic logic signed [RND_WIDTH-1:0] round_half(input logic signed [RND_WIDTH-1:0] v);
      return (v + RND_WIDTH'(1)) >>> 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdf_delay_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdf_delay_line: DEPTH x WIDTH circular buffer, asynchronous read, write on we.
// Rev 1.0
// ---------------------------------------------------------------------------
module sdf_delay_line
   import fft_pkg::*;
#(
   parameter int WIDTH  = 38,
   parameter int DEPTH  = 32,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Read-before-write: rdata shows the old word during the writing cycle.
   assign rdata = r_mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdf_bf_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdf_bf_stage: radix-2 single-path delay-feedback butterfly stage.
// Rev 1.0
// ---------------------------------------------------------------------------
module sdf_bf_stage
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH  = 18,
   parameter int DELAY       = 32,
   parameter int SCALE       = SCALE_FULL,
   localparam int OUT_WIDTH  = DATA_WIDTH + 1 - SCALE,
   localparam int IDX_WIDTH  = clog2(DELAY) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_r,
   input  logic signed [DATA_WIDTH-1:0] in_i,
   output logic                         out_valid,
   output logic signed [OUT_WIDTH-1:0]  out_r,
   output logic signed [OUT_WIDTH-1:0]  out_i,
   output logic [IDX_WIDTH-1:0]         out_idx,
   output logic                         out_last
);

   localparam int ADDR_WIDTH = IDX_WIDTH - 1;
   localparam int WORD_WIDTH = DATA_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DELAY - 1);

   logic [IDX_WIDTH-1:0]          r_cnt;
   logic                          r_primed;
   logic                          w_accept;
   logic                          w_emit;
   logic                          w_wrap;
   phase_e                        w_phase;
   logic [ADDR_WIDTH-1:0]         w_addr;
   logic signed [WORD_WIDTH-1:0]  w_yr, w_yi;
   logic signed [WORD_WIDTH-1:0]  w_xr, w_xi;
   logic signed [WORD_WIDTH-1:0]  w_sum_r, w_sum_i;
   logic signed [WORD_WIDTH-1:0]  w_dif_r, w_dif_i;
   logic signed [WORD_WIDTH-1:0]  w_sel_r, w_sel_i;
   logic signed [OUT_WIDTH-1:0]   w_res_r, w_res_i;
   logic [2*WORD_WIDTH-1:0]       w_rd_word;
   logic [2*WORD_WIDTH-1:0]       w_wr_word;

   assign w_accept = in_valid & ~clr;
   assign w_phase  = phase_e'(r_cnt[IDX_WIDTH-1]);
   assign w_addr   = r_cnt[ADDR_WIDTH-1:0];
   assign w_wrap   = &r_cnt;
   // Phase-A outputs are last frame's differences; only meaningful once a full frame has passed.
   assign w_emit   = w_accept & ((w_phase == PHASE_B) | r_primed);

   assign w_yr = {in_r[DATA_WIDTH-1], in_r};
   assign w_yi = {in_i[DATA_WIDTH-1], in_i};
   assign {w_xr, w_xi} = w_rd_word;

   assign w_sum_r = w_xr + w_yr;
   assign w_sum_i = w_xi + w_yi;
   assign w_dif_r = w_xr - w_yr;
   assign w_dif_i = w_xi - w_yi;

   assign w_sel_r   = (w_phase == PHASE_B) ? w_sum_r : w_xr;
   assign w_sel_i   = (w_phase == PHASE_B) ? w_sum_i : w_xi;
   assign w_wr_word = (w_phase == PHASE_B) ? {w_dif_r, w_dif_i} : {w_yr, w_yi};

   sdf_delay_line #(
      .WIDTH (2*WORD_WIDTH),
      .DEPTH (DELAY)
   ) u_delay_line (
      .clk   (clk),
      .we    (w_accept),
      .addr  (w_addr),
      .wdata (w_wr_word),
      .rdata (w_rd_word)
   );

   generate
      if (SCALE == SCALE_HALF) begin : g_half
         assign w_res_r = OUT_WIDTH'(round_half(RND_WIDTH'(w_sel_r)));
         assign w_res_i = OUT_WIDTH'(round_half(RND_WIDTH'(w_sel_i)));
      end else begin : g_full
         assign w_res_r = w_sel_r;
         assign w_res_i = w_sel_i;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_primed <= 1'b0;
      end else if (clr) begin
         r_cnt    <= '0;
         r_primed <= 1'b0;
      end else if (in_valid) begin
         r_cnt <= r_cnt + IDX_WIDTH'(1);
         if (w_wrap) begin
            r_primed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
      end else begin
         out_valid <= w_emit;
         if (w_emit) begin
            out_r    <= w_res_r;
            out_i    <= w_res_i;
            out_idx  <= {w_phase == PHASE_A, w_addr};
            out_last <= (w_phase == PHASE_A) && (w_addr == LAST_ADDR);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdf_bf_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdf_bf_stage: self-checking bench, three parameter sets of sdf_bf_stage.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sdf_bf_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Shared stimulus for the two DELAY=4 instances (full growth and halved).
   logic               a_clr = 1'b0, a_valid = 1'b0;
   logic signed [17:0] a_r = '0, a_i = '0;
   logic               r_clr = 1'b0, r_valid = 1'b0;
   logic signed [15:0] r_r = '0, r_i = '0;

   logic               f_valid, f_last;
   logic signed [18:0] f_r, f_i;
   logic [2:0]         f_idx;
   logic               h_valid, h_last;
   logic signed [17:0] h_r, h_i;
   logic [2:0]         h_idx;
   logic               q_valid, q_last;
   logic signed [16:0] q_r, q_i;
   logic [5:0]         q_idx;

   sdf_bf_stage #(.DATA_WIDTH(18), .DELAY(4), .SCALE(0)) dut_f (
      .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_valid), .in_r(a_r), .in_i(a_i),
      .out_valid(f_valid), .out_r(f_r), .out_i(f_i), .out_idx(f_idx), .out_last(f_last));

   sdf_bf_stage #(.DATA_WIDTH(18), .DELAY(4), .SCALE(1)) dut_h (
      .clk(clk), .rst(rst), .clr(a_clr), .in_valid(a_valid), .in_r(a_r), .in_i(a_i),
      .out_valid(h_valid), .out_r(h_r), .out_i(h_i), .out_idx(h_idx), .out_last(h_last));

   sdf_bf_stage #(.DATA_WIDTH(16), .DELAY(32), .SCALE(0)) dut_q (
      .clk(clk), .rst(rst), .clr(r_clr), .in_valid(r_valid), .in_r(r_r), .in_i(r_i),
      .out_valid(q_valid), .out_r(q_r), .out_i(q_i), .out_idx(q_idx), .out_last(q_last));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one frame = 2*D samples; first half is buffered, second half
   // produces sums, and the differences are released during the next frame's first half.
   int m_pos [3];
   bit m_primed [3];
   int m_ar [3][32];
   int m_ai [3][32];
   int m_dr [3][32];
   int m_di [3][32];
   bit e_v [3];
   int e_r [3];
   int e_i [3];
   int e_idx [3];
   bit e_last [3];

   typedef struct {
      int xr;
      bit ev;
      int er;
      int ei;
      int sr;
      int si;
      int eidx;
      bit elast;
   } vec_t;
   vec_t tbl [16];

   task automatic cmp(string name, int got, int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int wrap(int v, int w);
      int m;
      m = v & ((1 << w) - 1);
      if (m >= (1 << (w - 1))) m = m - (1 << w);
      return m;
   endfunction

   task automatic model_reset(int id);
      m_pos[id] = 0; m_primed[id] = 1'b0;
      e_v[id] = 1'b0; e_r[id] = 0; e_i[id] = 0; e_idx[id] = 0; e_last[id] = 1'b0;
   endtask

   task automatic emit(int id, int vr, int vi, int idx, bit last);
      if (id == 1) begin
         vr = wrap((vr + 1) >>> 1, 18);
         vi = wrap((vi + 1) >>> 1, 18);
      end
      e_v[id] = 1'b1; e_r[id] = vr; e_i[id] = vi; e_idx[id] = idx; e_last[id] = last;
   endtask

   task automatic model_step(int id, bit v, bit c, int xr, int xi);
      int d, n;
      d = (id == 2) ? 32 : 4;
      e_v[id] = 1'b0;
      if (c) begin
         m_pos[id] = 0; m_primed[id] = 1'b0;
      end else if (v) begin
         n = m_pos[id] % d;
         if (m_pos[id] < d) begin
            if (m_primed[id]) emit(id, m_dr[id][n], m_di[id][n], d + n, n == d - 1);
            m_ar[id][n] = xr; m_ai[id][n] = xi;
         end else begin
            emit(id, m_ar[id][n] + xr, m_ai[id][n] + xi, n, 1'b0);
            m_dr[id][n] = m_ar[id][n] - xr;
            m_di[id][n] = m_ai[id][n] - xi;
            if (m_pos[id] == 2 * d - 1) m_primed[id] = 1'b1;
         end
         m_pos[id] = (m_pos[id] + 1) % (2 * d);
      end
   endtask

   task automatic check_one(int id, int v, int r, int i, int idx, int last);
      cmp($sformatf("model%0d.valid", id), v, int'(e_v[id]));
      cmp($sformatf("model%0d.r", id), r, e_r[id]);
      cmp($sformatf("model%0d.i", id), i, e_i[id]);
      cmp($sformatf("model%0d.idx", id), idx, e_idx[id]);
      cmp($sformatf("model%0d.last", id), last, int'(e_last[id]));
   endtask

   task automatic tick();
      for (int id = 0; id < 3; id++) begin
         if (rst) model_reset(id);
         else if (id < 2) model_step(id, a_valid, a_clr, int'(a_r), int'(a_i));
         else model_step(id, r_valid, r_clr, int'(r_r), int'(r_i));
      end
      @(posedge clk);
      #1;
      check_one(0, f_valid, f_r, f_i, f_idx, f_last);
      check_one(1, h_valid, h_r, h_i, h_idx, h_last);
      check_one(2, q_valid, q_r, q_i, q_idx, q_last);
   endtask

   task automatic drive_a(bit v, bit c, int xr, int xi);
      a_valid = v; a_clr = c; a_r = 18'(xr); a_i = 18'(xi);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; a_valid = 1'b0; a_clr = 1'b0; r_valid = 1'b0; r_clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic check_zero(string tag);
      cmp({tag, ".f_valid"}, f_valid, 0); cmp({tag, ".f_r"}, f_r, 0); cmp({tag, ".f_i"}, f_i, 0);
      cmp({tag, ".f_idx"}, f_idx, 0);     cmp({tag, ".f_last"}, f_last, 0);
      cmp({tag, ".h_valid"}, h_valid, 0); cmp({tag, ".h_r"}, h_r, 0);
      cmp({tag, ".h_idx"}, h_idx, 0);     cmp({tag, ".h_last"}, h_last, 0);
   endtask

   task automatic run_table(int gap);
      for (int k = 0; k < 16; k++) begin
         drive_a(1'b1, 1'b0, tbl[k].xr, -tbl[k].xr);
         cmp($sformatf("tbl%0d[%0d].valid", gap, k), f_valid, int'(tbl[k].ev));
         cmp($sformatf("tbl%0d[%0d].hvalid", gap, k), h_valid, int'(tbl[k].ev));
         if (tbl[k].ev) begin
            cmp($sformatf("tbl%0d[%0d].r", gap, k), f_r, tbl[k].er);
            cmp($sformatf("tbl%0d[%0d].i", gap, k), f_i, tbl[k].ei);
            cmp($sformatf("tbl%0d[%0d].idx", gap, k), f_idx, tbl[k].eidx);
            cmp($sformatf("tbl%0d[%0d].last", gap, k), f_last, int'(tbl[k].elast));
            cmp($sformatf("tbl%0d[%0d].hr", gap, k), h_r, tbl[k].sr);
            cmp($sformatf("tbl%0d[%0d].hi", gap, k), h_i, tbl[k].si);
            cmp($sformatf("tbl%0d[%0d].hidx", gap, k), h_idx, tbl[k].eidx);
         end
         for (int g = 0; g < gap; g++) begin
            drive_a(1'b0, 1'b0, 0, 0);
            cmp($sformatf("gap[%0d].valid", k), f_valid, 0);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, last_at, n_last, xr, xi;

      // Real inputs 1..8 then 8 zeros; imaginary inputs are the negated real ones.
      tbl[0]  = '{1, 1'b0,   0,   0,  0,  0, 0, 1'b0};
      tbl[1]  = '{2, 1'b0,   0,   0,  0,  0, 0, 1'b0};
      tbl[2]  = '{3, 1'b0,   0,   0,  0,  0, 0, 1'b0};
      tbl[3]  = '{4, 1'b0,   0,   0,  0,  0, 0, 1'b0};
      tbl[4]  = '{5, 1'b1,   6,  -6,  3, -3, 0, 1'b0};
      tbl[5]  = '{6, 1'b1,   8,  -8,  4, -4, 1, 1'b0};
      tbl[6]  = '{7, 1'b1,  10, -10,  5, -5, 2, 1'b0};
      tbl[7]  = '{8, 1'b1,  12, -12,  6, -6, 3, 1'b0};
      tbl[8]  = '{0, 1'b1,  -4,   4, -2,  2, 4, 1'b0};
      tbl[9]  = '{0, 1'b1,  -4,   4, -2,  2, 5, 1'b0};
      tbl[10] = '{0, 1'b1,  -4,   4, -2,  2, 6, 1'b0};
      tbl[11] = '{0, 1'b1,  -4,   4, -2,  2, 7, 1'b1};
      tbl[12] = '{0, 1'b1,   0,   0,  0,  0, 0, 1'b0};
      tbl[13] = '{0, 1'b1,   0,   0,  0,  0, 1, 1'b0};
      tbl[14] = '{0, 1'b1,   0,   0,  0,  0, 2, 1'b0};
      tbl[15] = '{0, 1'b1,   0,   0,  0,  0, 3, 1'b0};

      do_reset();
      check_zero("reset");
      cmp("reset.q_valid", q_valid, 0);
      cmp("reset.q_idx", q_idx, 0);

      run_table(0);
      do_reset();
      run_table(3);

      // Halved output at the input extremes.
      do_reset();
      drive_a(1'b1, 1'b0, 131071, 131071);
      drive_a(1'b1, 1'b0, -131072, -131072);
      drive_a(1'b1, 1'b0, 0, 0);
      drive_a(1'b1, 1'b0, 0, 0);
      drive_a(1'b1, 1'b0, 131071, 131071);
      cmp("ext.sum0.hvalid", h_valid, 1);
      cmp("ext.sum0.hr", h_r, 131071);
      cmp("ext.sum0.fr", f_r, 262142);
      drive_a(1'b1, 1'b0, 131071, 131071);
      cmp("ext.sum1.hr", h_r, 0);
      cmp("ext.sum1.fr", f_r, -1);
      drive_a(1'b1, 1'b0, 0, 0);
      drive_a(1'b1, 1'b0, 0, 0);
      drive_a(1'b1, 1'b0, 0, 0);
      cmp("ext.dif0.hidx", h_idx, 4);
      cmp("ext.dif0.hr", h_r, 0);
      drive_a(1'b1, 1'b0, 0, 0);
      cmp("ext.dif1.hidx", h_idx, 5);
      cmp("ext.dif1.hr", h_r, -131071);
      cmp("ext.dif1.hi", h_i, -131071);
      cmp("ext.dif1.fr", f_r, -262143);
      for (int k = 0; k < 6; k++) drive_a(1'b1, 1'b0, 0, 0);

      // Asynchronous reset in the middle of phase B of a primed frame.
      for (int k = 0; k < 6; k++) drive_a(1'b1, 1'b0, 100 + k, -50 - k);
      #3 rst = 1'b1;
      #1 check_zero("async_rst");
      a_valid = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         drive_a(1'b1, 1'b0, 10 + k, 0);
         if (k < 4) cmp($sformatf("post_rst[%0d].valid", k), f_valid, 0);
         else cmp($sformatf("post_rst[%0d].idx", k), f_idx, k - 4);
      end
      cmp("post_rst.last_sum", f_r, 13 + 17);

      // Frame restart together with a valid input at cnt=5.
      for (int k = 0; k < 5; k++) drive_a(1'b1, 1'b0, 7 * k - 3, k);
      drive_a(1'b1, 1'b1, 99, 99);
      cmp("clr.valid", f_valid, 0);
      for (int k = 0; k < 4; k++) begin
         drive_a(1'b1, 1'b0, k + 1, 0);
         cmp($sformatf("clr_after[%0d].valid", k), f_valid, 0);
      end
      drive_a(1'b1, 1'b0, 5, 0);
      cmp("clr_first.valid", f_valid, 1);
      cmp("clr_first.idx", f_idx, 0);
      cmp("clr_first.r", f_r, 6);
      for (int k = 0; k < 3; k++) drive_a(1'b1, 1'b0, 0, 0);

      // Random traffic with gaps and occasional restarts on the DELAY=4 pair.
      for (int k = 0; k < 400; k++) begin
         xr = ($urandom_range(0, 7) == 0) ? 131071 : int'($signed(18'($urandom)));
         xi = ($urandom_range(0, 7) == 0) ? -131072 : int'($signed(18'($urandom)));
         drive_a($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, xr, xi);
      end
      a_valid = 1'b0; a_clr = 1'b0;

      // 1000 back-to-back random frames on the DELAY=32 instance.
      acc = 0; last_at = -1; n_last = 0;
      for (int k = 0; k < 64000; k++) begin
         r_valid = 1'b1; r_r = 16'($urandom); r_i = 16'($urandom);
         tick();
         acc++;
         if (q_valid && q_last) begin
            n_last++;
            if (last_at >= 0) cmp("rnd.last_spacing", acc - last_at, 64);
            else cmp("rnd.first_last", acc, 96);
            last_at = acc;
         end
      end
      r_valid = 1'b0;
      tick();
      cmp("rnd.last_count", n_last, 999);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
